// File: rtl/split_bus_arbiter.sv
// Two-master bus arbiter with split-transaction parking for one split-capable slave.
// All outputs come straight from flops; a grant follows its sampled request by one clock.
module split_bus_arbiter #(
    parameter bit RR_EN = 1'b1
) (
    input  logic clk,
    input  logic rstn,
    input  logic breq1,
    input  logic breq2,
    input  logic ssplit,
    output logic bgrant1,
    output logic bgrant2,
    output logic msplit1,
    output logic msplit2,
    output logic msel,
    output logic split_grant
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT1 = 2'd1,
        GRANT2 = 2'd2
    } state_t;

    state_t state_q;
    logic   bgrant1_q;
    logic   bgrant2_q;
    logic   msplit1_q;
    logic   msplit2_q;
    logic   msel_q;
    logic   split_grant_q;
    logic   split_pend_q;
    logic   split_owner_q;   // 0 = master 1, 1 = master 2
    logic   last_grant_q;    // 0 = master 1, 1 = master 2
    logic   ssplit_q;

    logic req1_d;
    logic req2_d;
    logic split_rise_d;
    logic tie_pick2_d;

    // A parked master's request is invisible until its split resumes.
    assign req1_d       = breq1 & ~msplit1_q;
    assign req2_d       = breq2 & ~msplit2_q;
    assign split_rise_d = ssplit & ~ssplit_q;
    assign tie_pick2_d  = RR_EN ? ~last_grant_q : 1'b0;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= IDLE;
            bgrant1_q     <= 1'b0;
            bgrant2_q     <= 1'b0;
            msplit1_q     <= 1'b0;
            msplit2_q     <= 1'b0;
            msel_q        <= 1'b0;
            split_grant_q <= 1'b0;
            split_pend_q  <= 1'b0;
            split_owner_q <= 1'b0;
            last_grant_q  <= 1'b1;
            ssplit_q      <= 1'b0;
        end else begin
            ssplit_q      <= ssplit;
            split_grant_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (split_pend_q && !ssplit) begin
                        // Returning the bus to the split owner outranks any fresh request.
                        split_pend_q  <= 1'b0;
                        split_grant_q <= 1'b1;
                        if (split_owner_q) begin
                            state_q      <= GRANT2;
                            bgrant2_q    <= 1'b1;
                            msplit2_q    <= 1'b0;
                            msel_q       <= 1'b1;
                            last_grant_q <= 1'b1;
                        end else begin
                            state_q      <= GRANT1;
                            bgrant1_q    <= 1'b1;
                            msplit1_q    <= 1'b0;
                            msel_q       <= 1'b0;
                            last_grant_q <= 1'b0;
                        end
                    end else if (req1_d && (!req2_d || !tie_pick2_d)) begin
                        state_q      <= GRANT1;
                        bgrant1_q    <= 1'b1;
                        msel_q       <= 1'b0;
                        last_grant_q <= 1'b0;
                    end else if (req2_d) begin
                        state_q      <= GRANT2;
                        bgrant2_q    <= 1'b1;
                        msel_q       <= 1'b1;
                        last_grant_q <= 1'b1;
                    end
                end
                GRANT1: begin
                    if (split_rise_d && !split_pend_q) begin
                        state_q       <= IDLE;
                        bgrant1_q     <= 1'b0;
                        msplit1_q     <= 1'b1;
                        split_pend_q  <= 1'b1;
                        split_owner_q <= 1'b0;
                    end else if (!breq1) begin
                        state_q   <= IDLE;
                        bgrant1_q <= 1'b0;
                    end
                end
                GRANT2: begin
                    if (split_rise_d && !split_pend_q) begin
                        state_q       <= IDLE;
                        bgrant2_q     <= 1'b0;
                        msplit2_q     <= 1'b1;
                        split_pend_q  <= 1'b1;
                        split_owner_q <= 1'b1;
                    end else if (!breq2) begin
                        state_q   <= IDLE;
                        bgrant2_q <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    bgrant1_q <= 1'b0;
                    bgrant2_q <= 1'b0;
                end
            endcase
        end
    end

    assign bgrant1     = bgrant1_q;
    assign bgrant2     = bgrant2_q;
    assign msplit1     = msplit1_q;
    assign msplit2     = msplit2_q;
    assign msel        = msel_q;
    assign split_grant = split_grant_q;

endmodule

// File: tb/tb_split_bus_arbiter.sv
// Bench for split_bus_arbiter: directed vector table, hand sequences for reset and
// fixed priority, then random traffic against a transaction-level ownership model.
module tb_split_bus_arbiter;

    logic clk = 1'b0;
    logic rstn;
    logic breq1, breq2, ssplit;

    logic bg1_a, bg2_a, ms1_a, ms2_a, sel_a, sg_a;
    logic bg1_b, bg2_b, ms1_b, ms2_b, sel_b, sg_b;
    logic [5:0] out_a, out_b;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    split_bus_arbiter #(.RR_EN(1'b1)) dut_rr (
        .clk(clk), .rstn(rstn), .breq1(breq1), .breq2(breq2), .ssplit(ssplit),
        .bgrant1(bg1_a), .bgrant2(bg2_a), .msplit1(ms1_a), .msplit2(ms2_a),
        .msel(sel_a), .split_grant(sg_a)
    );

    split_bus_arbiter #(.RR_EN(1'b0)) dut_fp (
        .clk(clk), .rstn(rstn), .breq1(breq1), .breq2(breq2), .ssplit(ssplit),
        .bgrant1(bg1_b), .bgrant2(bg2_b), .msplit1(ms1_b), .msplit2(ms2_b),
        .msel(sel_b), .split_grant(sg_b)
    );

    // Output bit order: {bgrant1, bgrant2, msplit1, msplit2, msel, split_grant}
    assign out_a = {bg1_a, bg2_a, ms1_a, ms2_a, sel_a, sg_a};
    assign out_b = {bg1_b, bg2_b, ms1_b, ms2_b, sel_b, sg_b};

    typedef struct packed {
        logic       b1;
        logic       b2;
        logic       s;
        logic [5:0] exp;
    } vec_t;

    vec_t vecs[31];
    vec_t mid[3];

    // Reference model: who owns the bus (0 = nobody), who is parked on a split.
    // Index 0 models the round-robin instance, index 1 the fixed-priority one.
    int m_hold[2];
    int m_park[2];
    int m_last[2];
    int m_mux[2];
    bit m_sg[2];
    bit m_prev[2];

    task automatic chk(input string nm, input logic [5:0] act, input logic [5:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_hold[k] = 0; m_park[k] = 0; m_last[k] = 2;
            m_mux[k]  = 0; m_sg[k]   = 1'b0; m_prev[k] = 1'b0;
        end
    endtask

    task automatic model_step(input int k, input bit b1, input bit b2, input bit s);
        bit r1, r2;
        int w;
        m_sg[k] = 1'b0;
        if (m_hold[k] == 0) begin
            if (m_park[k] != 0 && !s) begin
                m_hold[k] = m_park[k];
                m_park[k] = 0;
                m_sg[k]   = 1'b1;
            end else begin
                r1 = b1 && (m_park[k] != 1);
                r2 = b2 && (m_park[k] != 2);
                w  = 0;
                if (r1 && r2)  w = (k == 0) ? (3 - m_last[k]) : 1;
                else if (r1)   w = 1;
                else if (r2)   w = 2;
                m_hold[k] = w;
            end
            if (m_hold[k] != 0) begin
                m_last[k] = m_hold[k];
                m_mux[k]  = m_hold[k] - 1;
            end
        end else begin
            if (s && !m_prev[k] && m_park[k] == 0) begin
                m_park[k] = m_hold[k];
                m_hold[k] = 0;
            end else if (!((m_hold[k] == 1) ? b1 : b2)) begin
                m_hold[k] = 0;
            end
        end
        m_prev[k] = s;
    endtask

    function automatic logic [5:0] model_out(input int k);
        return {m_hold[k] == 1, m_hold[k] == 2, m_park[k] == 1, m_park[k] == 2,
                m_mux[k] == 1, m_sg[k]};
    endfunction

    task automatic do_reset();
        breq1 = 1'b0; breq2 = 1'b0; ssplit = 1'b0;
        #2 rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        model_reset();
    endtask

    initial begin
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 6'b100000};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 6'b100000};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 6'b100000};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 6'b100000};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 6'b100000};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 6'b000000};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 6'b000000};
        vecs[7]  = '{1'b1, 1'b1, 1'b0, 6'b010010};
        vecs[8]  = '{1'b1, 1'b1, 1'b0, 6'b010010};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 6'b000010};
        vecs[10] = '{1'b1, 1'b1, 1'b0, 6'b100000};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 6'b000000};
        vecs[12] = '{1'b1, 1'b1, 1'b0, 6'b010010};
        vecs[13] = '{1'b1, 1'b0, 1'b0, 6'b000010};
        vecs[14] = '{1'b1, 1'b1, 1'b0, 6'b100000};
        vecs[15] = '{1'b1, 1'b1, 1'b1, 6'b001000};
        vecs[16] = '{1'b1, 1'b1, 1'b1, 6'b011010};
        vecs[17] = '{1'b1, 1'b1, 1'b0, 6'b011010};
        vecs[18] = '{1'b1, 1'b0, 1'b0, 6'b001010};
        vecs[19] = '{1'b1, 1'b0, 1'b0, 6'b100001};
        vecs[20] = '{1'b1, 1'b0, 1'b0, 6'b100000};
        vecs[21] = '{1'b0, 1'b0, 1'b0, 6'b000000};
        vecs[22] = '{1'b0, 1'b1, 1'b0, 6'b010010};
        vecs[23] = '{1'b1, 1'b1, 1'b1, 6'b000110};
        vecs[24] = '{1'b1, 1'b1, 1'b0, 6'b010011};
        vecs[25] = '{1'b1, 1'b1, 1'b0, 6'b010010};
        vecs[26] = '{1'b1, 1'b0, 1'b0, 6'b000010};
        vecs[27] = '{1'b1, 1'b0, 1'b0, 6'b100000};
        vecs[28] = '{1'b0, 1'b0, 1'b0, 6'b000000};
        vecs[29] = '{1'b0, 1'b0, 1'b1, 6'b000000};
        vecs[30] = '{1'b0, 1'b0, 1'b0, 6'b000000};
        mid[0]   = '{1'b1, 1'b0, 1'b0, 6'b100000};
        mid[1]   = '{1'b1, 1'b1, 1'b1, 6'b001000};
        mid[2]   = '{1'b1, 1'b1, 1'b1, 6'b011010};

        rstn = 1'b1; breq1 = 1'b0; breq2 = 1'b0; ssplit = 1'b0;
        #1 rstn = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("reset_rr", out_a, 6'b000000);
        chk("reset_fp", out_b, 6'b000000);
        $display("txn reset rr=%b fp=%b", out_a, out_b);
        rstn = 1'b1;

        for (int i = 0; i < 31; i++) begin
            breq1 = vecs[i].b1; breq2 = vecs[i].b2; ssplit = vecs[i].s;
            @(negedge clk);
            chk($sformatf("vec%0d", i), out_a, vecs[i].exp);
            $display("txn vec%0d b1=%b b2=%b s=%b out=%b", i, vecs[i].b1, vecs[i].b2,
                     vecs[i].s, out_a);
        end

        // Park master 1 on a split with master 2 owning the bus, then reset mid-cycle.
        for (int i = 0; i < 3; i++) begin
            breq1 = mid[i].b1; breq2 = mid[i].b2; ssplit = mid[i].s;
            @(negedge clk);
            chk($sformatf("mid%0d", i), out_a, mid[i].exp);
            $display("txn mid%0d out=%b", i, out_a);
        end
        #2 rstn = 1'b0;
        #1;
        chk("async_rst_rr", out_a, 6'b000000);
        chk("async_rst_fp", out_b, 6'b000000);
        $display("txn async_reset rr=%b fp=%b", out_a, out_b);
        @(negedge clk);
        breq1 = 1'b0; breq2 = 1'b0; ssplit = 1'b1;
        rstn = 1'b1;
        @(negedge clk);
        chk("post_rst_idle", out_a, 6'b000000);
        ssplit = 1'b0;
        @(negedge clk);
        chk("post_rst_nosg0", out_a, 6'b000000);
        @(negedge clk);
        chk("post_rst_nosg1", out_a, 6'b000000);
        $display("txn post_reset out=%b", out_a);

        // Fixed priority: master 1 takes every tie, master 2 never granted.
        do_reset();
        for (int r = 0; r < 3; r++) begin
            breq1 = 1'b1; breq2 = 1'b1;
            @(negedge clk);
            chk($sformatf("fp_tie%0d", r), out_b, 6'b100000);
            @(negedge clk);
            chk($sformatf("fp_hold%0d", r), out_b, 6'b100000);
            breq1 = 1'b0;
            @(negedge clk);
            chk($sformatf("fp_rel%0d", r), out_b, 6'b000000);
            $display("txn fp_round%0d out=%b", r, out_b);
        end

        do_reset();
        for (int c = 0; c < 400; c++) begin
            chk($sformatf("rand_rr%0d", c), out_a, model_out(0));
            chk($sformatf("rand_fp%0d", c), out_b, model_out(1));
            if (bg1_a && bg2_a) begin
                n_err++;
                $display("FAIL rand_dual_grant%0d: got both grants required one", c);
            end
            breq1 = ($urandom_range(0, 99) < 70);
            breq2 = ($urandom_range(0, 99) < 70);
            if ($urandom_range(0, 99) < 15) ssplit = ~ssplit;
            model_step(0, breq1, breq2, ssplit);
            model_step(1, breq1, breq2, ssplit);
            @(negedge clk);
            $display("txn rand%0d b1=%b b2=%b s=%b rr=%b fp=%b", c, breq1, breq2, ssplit,
                     out_a, out_b);
        end
        chk("rand_final_rr", out_a, model_out(0));
        chk("rand_final_fp", out_b, model_out(1));

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
